// File: rtl/mux2_arb_pkg.sv
// Shared types for the two-requester round-robin arbiter.
//   arb_state_e : packet-lock state of the arbiter
//   src_e       : requester identifier (also the encoding of out_src / sel_b)
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way priority pick used for the idle-state grant decision.
// Ports:
//   req   [1:0] in  request vector, bit 0 = A, bit 1 = B
//   prio        in  preferred requester when both request (0 = A, 1 = B)
//   grant [1:0] out one-hot (or zero) grant, same bit order as req
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    // A requester wins if it is alone, or if both request and it holds priority.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | ~prio);
        grant[1] = req[1] & (~req[0] |  prio);
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin packet arbiter feeding one registered output stage.
// The grant is held for a whole packet (delimited by *_last) and priority
// alternates between packets.
// Ports:
//   clk, areset_n                 clock, asynchronous active-low reset
//   a_valid/a_data/a_last/a_ready requester A beat handshake
//   b_valid/b_data/b_last/b_ready requester B beat handshake
//   out_valid/out_data/out_last/out_src/out_ready  registered output handshake
//   sel_b                         combinational datapath select (1 = B routed)
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int START_PRIO = 0
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel_b
);

    localparam src_e PRIO_INIT = (START_PRIO != 0) ? SRC_B : SRC_A;

    arb_state_e       state_reg, state_next;
    src_e             prio_reg, prio_next;
    logic             sel_hold_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic             out_src_reg;

    logic [1:0]       pick;
    logic             grant_a;
    logic             grant_b;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] beat_data;
    logic             beat_last;

    rr_pick2 u_pick (
        .req   ({b_valid, a_valid}),
        .prio  (prio_reg == SRC_B),
        .grant (pick)
    );

    // The output register may take a new beat when empty or being drained.
    assign load    = ~out_valid_reg | out_ready;
    assign a_ready = load & grant_a & a_valid;
    assign b_ready = load & grant_b & b_valid;
    assign xfer    = a_ready | b_ready;

    // Shared 2:1 datapath steered by sel_b; only used when a transfer occurs,
    // at which point sel_b always names the transferring requester.
    assign beat_data = sel_b ? b_data : a_data;
    assign beat_last = sel_b ? b_last : a_last;

    // Grant / select / next-state logic.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        sel_b      = sel_hold_reg;
        state_next = state_reg;
        prio_next  = prio_reg;

        case (state_reg)
            LOCK_A: begin
                grant_a = 1'b1;
                sel_b   = 1'b0;
            end
            LOCK_B: begin
                grant_b = 1'b1;
                sel_b   = 1'b1;
            end
            default: begin
                grant_a = pick[0];
                grant_b = pick[1];
                // With no request the select keeps its last value so the
                // downstream mux does not toggle needlessly.
                if (pick[1]) begin
                    sel_b = 1'b1;
                end else if (pick[0]) begin
                    sel_b = 1'b0;
                end
            end
        endcase

        if (a_ready) begin
            if (a_last) begin
                state_next = IDLE;
                prio_next  = SRC_B;
            end else begin
                state_next = LOCK_A;
            end
        end else if (b_ready) begin
            if (b_last) begin
                state_next = IDLE;
                prio_next  = SRC_A;
            end else begin
                state_next = LOCK_B;
            end
        end
    end

    // Arbitration state.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_reg    <= IDLE;
            prio_reg     <= PRIO_INIT;
            sel_hold_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prio_reg     <= prio_next;
            sel_hold_reg <= sel_b;
        end
    end

    // Output stage: load on transfer, otherwise drop valid once consumed.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_src_reg   <= 1'b0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= beat_data;
            out_last_reg  <= beat_last;
            out_src_reg   <= b_ready;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_src   = out_src_reg;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter (WIDTH=8, START_PRIO=0).
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       areset_n;
    logic       a_valid, a_last, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [7:0] b_data;
    logic       out_valid, out_last, out_src, out_ready, sel_b;
    logic [7:0] out_data;

    int n_cmp;
    int n_err;

    mux2_rr_arbiter #(.WIDTH(8), .START_PRIO(0)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel_b     (sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       al;
        logic       bv;
        logic [7:0] bd;
        logic       bl;
        logic       ordy;
        logic       e_ar;
        logic       e_br;
        logic       e_sel;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
        logic       e_os;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [7:0] ad, input logic al,
                                input logic bv, input logic [7:0] bd, input logic bl,
                                input logic ordy, input logic e_ar, input logic e_br,
                                input logic e_sel, input logic e_ov, input logic [7:0] e_od,
                                input logic e_ol, input logic e_os);
        vec_t v;
        v.av = av; v.ad = ad; v.al = al;
        v.bv = bv; v.bd = bd; v.bl = bl;
        v.ordy = ordy;
        v.e_ar = e_ar; v.e_br = e_br; v.e_sel = e_sel;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_os = e_os;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, check combinational outputs just before the
    // rising edge, check registered outputs 1 time unit after it.
    task automatic step(input string tag, input vec_t v);
        a_valid = v.av; a_data = v.ad; a_last = v.al;
        b_valid = v.bv; b_data = v.bd; b_last = v.bl;
        out_ready = v.ordy;
        #4;
        chk({tag, ".a_ready"}, {7'd0, a_ready}, {7'd0, v.e_ar});
        chk({tag, ".b_ready"}, {7'd0, b_ready}, {7'd0, v.e_br});
        chk({tag, ".sel_b"},   {7'd0, sel_b},   {7'd0, v.e_sel});
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, v.e_ov});
        if (v.e_ov) begin
            chk({tag, ".out_data"}, out_data, v.e_od);
            chk({tag, ".out_last"}, {7'd0, out_last}, {7'd0, v.e_ol});
            chk({tag, ".out_src"},  {7'd0, out_src},  {7'd0, v.e_os});
        end
        $display("%s: ar=%0b br=%0b sel=%0b -> ov=%0b od=0x%02h ol=%0b os=%0b",
                 tag, a_ready, b_ready, sel_b, out_valid, out_data, out_last, out_src);
        @(negedge clk);
    endtask

    // Assert reset on a falling edge and check outputs clear without a clock edge.
    task automatic pulse_reset(input string tag);
        areset_n = 1'b0;
        #1;
        chk({tag, ".rst_out_valid"}, {7'd0, out_valid}, 8'd0);
        chk({tag, ".rst_out_data"},  out_data, 8'd0);
        chk({tag, ".rst_out_last"},  {7'd0, out_last}, 8'd0);
        chk({tag, ".rst_out_src"},   {7'd0, out_src},  8'd0);
        $display("%s: reset asserted, ov=%0b od=0x%02h", tag, out_valid, out_data);
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    vec_t tbl [23];

    initial begin
        n_cmp = 0;
        n_err = 0;
        areset_n  = 1'b1;
        a_valid   = 1'b0; a_data = 8'h00; a_last = 1'b0;
        b_valid   = 1'b0; b_data = 8'h00; b_last = 1'b0;
        out_ready = 1'b0;

        //           av ad     al  bv bd     bl ordy ar br sel ov od     ol os
        // alternating single-beat packets, priority starts at A
        tbl[0]  = mk(1, 8'h11, 1,  1, 8'h22, 1, 1,   1, 0, 0,  1, 8'h11, 1, 0);
        tbl[1]  = mk(1, 8'h11, 1,  1, 8'h22, 1, 1,   0, 1, 1,  1, 8'h22, 1, 1);
        tbl[2]  = mk(1, 8'h11, 1,  1, 8'h22, 1, 1,   1, 0, 0,  1, 8'h11, 1, 0);
        tbl[3]  = mk(1, 8'h11, 1,  1, 8'h22, 1, 1,   0, 1, 1,  1, 8'h22, 1, 1);
        // A 3-beat packet while B waits
        tbl[4]  = mk(1, 8'hA0, 0,  1, 8'h22, 1, 1,   1, 0, 0,  1, 8'hA0, 0, 0);
        tbl[5]  = mk(1, 8'hA1, 0,  1, 8'h22, 1, 1,   1, 0, 0,  1, 8'hA1, 0, 0);
        tbl[6]  = mk(1, 8'hA2, 1,  1, 8'h22, 1, 1,   1, 0, 0,  1, 8'hA2, 1, 0);
        tbl[7]  = mk(1, 8'h11, 1,  1, 8'h22, 1, 1,   0, 1, 1,  1, 8'h22, 1, 1);
        // backpressure: hold 0x55 for 4 cycles, then drain and load together
        tbl[8]  = mk(1, 8'h55, 1,  0, 8'h00, 0, 1,   1, 0, 0,  1, 8'h55, 1, 0);
        tbl[9]  = mk(1, 8'h66, 1,  0, 8'h00, 0, 0,   0, 0, 0,  1, 8'h55, 1, 0);
        tbl[10] = mk(1, 8'h66, 1,  0, 8'h00, 0, 0,   0, 0, 0,  1, 8'h55, 1, 0);
        tbl[11] = mk(1, 8'h66, 1,  0, 8'h00, 0, 0,   0, 0, 0,  1, 8'h55, 1, 0);
        tbl[12] = mk(1, 8'h66, 1,  0, 8'h00, 0, 0,   0, 0, 0,  1, 8'h55, 1, 0);
        tbl[13] = mk(1, 8'h66, 1,  0, 8'h00, 0, 1,   1, 0, 0,  1, 8'h66, 1, 0);
        // LOCK_B with B stalling while A waits
        tbl[14] = mk(1, 8'h77, 1,  1, 8'hB0, 0, 1,   0, 1, 1,  1, 8'hB0, 0, 1);
        tbl[15] = mk(1, 8'h77, 1,  0, 8'h00, 0, 1,   0, 0, 1,  0, 8'h00, 0, 0);
        tbl[16] = mk(1, 8'h77, 1,  0, 8'h00, 0, 1,   0, 0, 1,  0, 8'h00, 0, 0);
        tbl[17] = mk(1, 8'h77, 1,  1, 8'hB1, 1, 1,   0, 1, 1,  1, 8'hB1, 1, 1);
        tbl[18] = mk(1, 8'h77, 1,  1, 8'h22, 1, 1,   1, 0, 0,  1, 8'h77, 1, 0);
        // idle keeps sel_b; empty output loads even with out_ready=0
        tbl[19] = mk(0, 8'h00, 0,  0, 8'h00, 0, 1,   0, 0, 0,  0, 8'h00, 0, 0);
        tbl[20] = mk(0, 8'h00, 0,  1, 8'h33, 1, 0,   0, 1, 1,  1, 8'h33, 1, 1);
        tbl[21] = mk(0, 8'h00, 0,  0, 8'h00, 0, 0,   0, 0, 1,  1, 8'h33, 1, 1);
        tbl[22] = mk(0, 8'h00, 0,  0, 8'h00, 0, 1,   0, 0, 1,  0, 8'h00, 0, 0);

        @(negedge clk);
        pulse_reset("init");
        @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset mid-packet restores START_PRIO: first make prio=B and lock A.
        step("seqR.a1", mk(1, 8'hC0, 1, 0, 8'h00, 0, 1,  1, 0, 0,  1, 8'hC0, 1, 0));
        step("seqR.a2", mk(1, 8'hC1, 0, 0, 8'h00, 0, 1,  1, 0, 0,  1, 8'hC1, 0, 0));
        pulse_reset("seqR");
        step("seqR.both", mk(1, 8'h11, 1, 1, 8'h22, 1, 1,  1, 0, 0,  1, 8'h11, 1, 0));

        // Reset mid-packet returns to IDLE: lock A, reset, then only B requests.
        step("seqS.a1", mk(1, 8'hD0, 0, 0, 8'h00, 0, 1,  1, 0, 0,  1, 8'hD0, 0, 0));
        pulse_reset("seqS");
        step("seqS.bonly", mk(0, 8'h00, 0, 1, 8'h44, 1, 1,  0, 1, 1,  1, 8'h44, 1, 1));
        step("seqS.drain", mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 1,  0, 8'h00, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
